// File: rtl/tlb_ptw_pkg.sv
// Shared definitions for the TLB page-table walker.
//   - PTE bit positions (Sv32-style PTE layout)
//   - walker FSM state type
//   - {U,X,W,R} flag packing helper, shared with the TLB
package tlb_ptw_pkg;

   localparam int unsigned PTE_V       = 0;
   localparam int unsigned PTE_R       = 1;
   localparam int unsigned PTE_W       = 2;
   localparam int unsigned PTE_X       = 3;
   localparam int unsigned PTE_U       = 4;
   localparam int unsigned PTE_G       = 5;
   localparam int unsigned PTE_A       = 6;
   localparam int unsigned PTE_D       = 7;
   localparam int unsigned PTE_PPN_LSB = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L1_REQ,
      ST_L1_WAIT,
      ST_L0_REQ,
      ST_L0_WAIT,
      ST_DONE,
      ST_FAULT
   } ptw_state_e;

   // Flag packing order used by both the TLB and the walker.
   function automatic logic [3:0] pack_flags(input logic u, input logic x,
                                             input logic w, input logic r);
      return {u, x, w, r};
   endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE decoder for the page-table walker.
// Ports:
//   pte_i        : raw 32-bit PTE returned by memory
//   level_i      : 1 = level-1 (root) PTE, 0 = level-0 PTE
//   is_leaf_o    : PTE is a leaf (R or X set)
//   fault_o      : PTE is illegal at this level (bus errors handled by caller)
//   flags4_o     : leaf permissions {U,X,W,R}
//   g_o          : global bit
//   ppn20_o      : PTE physical page number
//   misaligned_o : level-1 leaf whose low PPN bits are not zero
module ptw_pte_check
   import tlb_ptw_pkg::*;
(
   input  logic [31:0] pte_i,
   input  logic        level_i,
   output logic        is_leaf_o,
   output logic        fault_o,
   output logic [3:0]  flags4_o,
   output logic        g_o,
   output logic [19:0] ppn20_o,
   output logic        misaligned_o
);

   logic v, r, w, x, u, a;
   logic unused_bits;

   assign v = pte_i[PTE_V];
   assign r = pte_i[PTE_R];
   assign w = pte_i[PTE_W];
   assign x = pte_i[PTE_X];
   assign u = pte_i[PTE_U];
   assign a = pte_i[PTE_A];

   // D is never written back and RSW is software-only.
   assign unused_bits = ^{pte_i[PTE_D], pte_i[9:8]};

   assign is_leaf_o    = r | x;
   assign flags4_o     = pack_flags(u, x, w, r);
   assign g_o          = pte_i[PTE_G];
   assign ppn20_o      = pte_i[PTE_PPN_LSB +: 20];
   assign misaligned_o = level_i & is_leaf_o & (ppn20_o[9:0] != '0);

   assign fault_o = ~v
                  | (~r & w)
                  | (pte_i[31:30] != 2'b00)
                  | (is_leaf_o & ~a)
                  | (~is_leaf_o & ~level_i)
                  | misaligned_o;

endmodule

// File: rtl/tlb_ptw.sv
// Two-level Sv32-style hardware page-table walker servicing TLB misses.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   miss_valid/ready, miss_vpn/asid  : miss request from the TLB
//   root_ppn                         : level-1 table base, sampled on accept
//   flush                            : sfence, kills the walk in progress
//   mem_req_*                        : single-outstanding PTE read request
//   mem_resp_*                       : PTE read response (data, bus error)
//   refill_*                         : one-cycle refill pulse + held translation
//   fault_valid/fault_vpn            : one-cycle page-fault pulse
//   busy, walk_count                 : status, completed refill count
module tlb_ptw
   import tlb_ptw_pkg::*;
#(
   parameter int unsigned VPN_WIDTH  = 20,
   parameter int unsigned PPN_WIDTH  = 20,
   parameter int unsigned ASID_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_valid,
   output logic                  miss_ready,
   input  logic [VPN_WIDTH-1:0]  miss_vpn,
   input  logic [ASID_WIDTH-1:0] miss_asid,
   input  logic [PPN_WIDTH-1:0]  root_ppn,
   input  logic                  flush,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [31:0]           mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [31:0]           mem_resp_data,
   input  logic                  mem_resp_err,
   output logic                  refill_valid,
   output logic [VPN_WIDTH-1:0]  refill_vpn,
   output logic [PPN_WIDTH-1:0]  refill_ppn,
   output logic [ASID_WIDTH-1:0] refill_asid,
   output logic [3:0]            refill_flags,
   output logic                  refill_global,
   output logic                  fault_valid,
   output logic [VPN_WIDTH-1:0]  fault_vpn,
   output logic                  busy,
   output logic [15:0]           walk_count
);

   ptw_state_e state_q, state_d;

   logic [VPN_WIDTH-1:0]  vpn_q, vpn_d;
   logic [ASID_WIDTH-1:0] asid_q, asid_d;
   logic [PPN_WIDTH-1:0]  root_q, root_d;
   logic [PPN_WIDTH-1:0]  l1ppn_q, l1ppn_d;
   logic                  gacc_q, gacc_d;
   logic                  kill_q, kill_d;

   logic [VPN_WIDTH-1:0]  rf_vpn_q, rf_vpn_d;
   logic [PPN_WIDTH-1:0]  rf_ppn_q, rf_ppn_d;
   logic [ASID_WIDTH-1:0] rf_asid_q, rf_asid_d;
   logic [3:0]            rf_flags_q, rf_flags_d;
   logic                  rf_global_q, rf_global_d;
   logic [VPN_WIDTH-1:0]  fault_vpn_q, fault_vpn_d;
   logic [15:0]           walk_count_q, walk_count_d;

   logic                  pte_level;
   logic                  pte_leaf;
   logic                  pte_fault;
   logic [3:0]            pte_flags;
   logic                  pte_g;
   logic [19:0]           pte_ppn;
   logic                  unused_misaligned;

   assign pte_level = (state_q == ST_L1_WAIT);

   ptw_pte_check u_pte_check (
      .pte_i        (mem_resp_data),
      .level_i      (pte_level),
      .is_leaf_o    (pte_leaf),
      .fault_o      (pte_fault),
      .flags4_o     (pte_flags),
      .g_o          (pte_g),
      .ppn20_o      (pte_ppn),
      .misaligned_o (unused_misaligned)
   );

   always_comb begin
      state_d      = state_q;
      vpn_d        = vpn_q;
      asid_d       = asid_q;
      root_d       = root_q;
      l1ppn_d      = l1ppn_q;
      gacc_d       = gacc_q;
      kill_d       = kill_q;
      rf_vpn_d     = rf_vpn_q;
      rf_ppn_d     = rf_ppn_q;
      rf_asid_d    = rf_asid_q;
      rf_flags_d   = rf_flags_q;
      rf_global_d  = rf_global_q;
      fault_vpn_d  = fault_vpn_q;
      walk_count_d = walk_count_q;
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;

      case (state_q)
         ST_IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               state_d = ST_L1_REQ;
               vpn_d   = miss_vpn;
               asid_d  = miss_asid;
               root_d  = root_ppn;
               gacc_d  = 1'b0;
               // A flush coinciding with the accept kills the walk before
               // any memory request goes out.
               kill_d  = flush;
            end
         end

         ST_L1_REQ, ST_L0_REQ: begin
            mem_req_valid = ~kill_q;
            mem_req_addr  = (state_q == ST_L1_REQ) ? {root_q, vpn_q[19:10], 2'b00}
                                                   : {l1ppn_q, vpn_q[9:0], 2'b00};
            if (kill_q || (flush && !mem_req_ready)) begin
               state_d = ST_IDLE;
            end else if (mem_req_ready) begin
               // Request already issued: a flush now must still drain the response.
               state_d = (state_q == ST_L1_REQ) ? ST_L1_WAIT : ST_L0_WAIT;
               kill_d  = flush;
            end
         end

         ST_L1_WAIT, ST_L0_WAIT: begin
            if (mem_resp_valid) begin
               if (kill_q || flush) begin
                  state_d = ST_IDLE;
               end else if (mem_resp_err || pte_fault) begin
                  state_d     = ST_FAULT;
                  fault_vpn_d = vpn_q;
               end else if (pte_leaf) begin
                  state_d     = ST_DONE;
                  rf_vpn_d    = vpn_q;
                  rf_asid_d   = asid_q;
                  rf_flags_d  = pte_flags;
                  rf_global_d = gacc_q | pte_g;
                  rf_ppn_d    = pte_level ? {pte_ppn[19:10], vpn_q[9:0]} : pte_ppn;
               end else begin
                  state_d = ST_L0_REQ;
                  l1ppn_d = pte_ppn;
                  gacc_d  = pte_g;
               end
            end else if (flush) begin
               kill_d = 1'b1;
            end
         end

         ST_DONE: begin
            state_d      = ST_IDLE;
            walk_count_d = walk_count_q + 16'd1;
         end

         ST_FAULT: begin
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) begin
         kill_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         vpn_q        <= '0;
         asid_q       <= '0;
         root_q       <= '0;
         l1ppn_q      <= '0;
         gacc_q       <= 1'b0;
         kill_q       <= 1'b0;
         rf_vpn_q     <= '0;
         rf_ppn_q     <= '0;
         rf_asid_q    <= '0;
         rf_flags_q   <= '0;
         rf_global_q  <= 1'b0;
         fault_vpn_q  <= '0;
         walk_count_q <= '0;
      end else begin
         state_q      <= state_d;
         vpn_q        <= vpn_d;
         asid_q       <= asid_d;
         root_q       <= root_d;
         l1ppn_q      <= l1ppn_d;
         gacc_q       <= gacc_d;
         kill_q       <= kill_d;
         rf_vpn_q     <= rf_vpn_d;
         rf_ppn_q     <= rf_ppn_d;
         rf_asid_q    <= rf_asid_d;
         rf_flags_q   <= rf_flags_d;
         rf_global_q  <= rf_global_d;
         fault_vpn_q  <= fault_vpn_d;
         walk_count_q <= walk_count_d;
      end
   end

   assign refill_valid  = (state_q == ST_DONE);
   assign fault_valid   = (state_q == ST_FAULT);
   assign busy          = (state_q != ST_IDLE);
   assign refill_vpn    = rf_vpn_q;
   assign refill_ppn    = rf_ppn_q;
   assign refill_asid   = rf_asid_q;
   assign refill_flags  = rf_flags_q;
   assign refill_global = rf_global_q;
   assign fault_vpn     = fault_vpn_q;
   assign walk_count    = walk_count_q;

endmodule

// File: tb/tb_tlb_ptw.sv
module tb_tlb_ptw;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        miss_valid;
   logic        miss_ready;
   logic [19:0] miss_vpn;
   logic [7:0]  miss_asid;
   logic [19:0] root_ppn;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        refill_valid;
   logic [19:0] refill_vpn;
   logic [19:0] refill_ppn;
   logic [7:0]  refill_asid;
   logic [3:0]  refill_flags;
   logic        refill_global;
   logic        fault_valid;
   logic [19:0] fault_vpn;
   logic        busy;
   logic [15:0] walk_count;

   tlb_ptw #(.VPN_WIDTH(20), .PPN_WIDTH(20), .ASID_WIDTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .miss_valid     (miss_valid),
      .miss_ready     (miss_ready),
      .miss_vpn       (miss_vpn),
      .miss_asid      (miss_asid),
      .root_ppn       (root_ppn),
      .flush          (flush),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .refill_valid   (refill_valid),
      .refill_vpn     (refill_vpn),
      .refill_ppn     (refill_ppn),
      .refill_asid    (refill_asid),
      .refill_flags   (refill_flags),
      .refill_global  (refill_global),
      .fault_valid    (fault_valid),
      .fault_vpn      (fault_vpn),
      .busy           (busy),
      .walk_count     (walk_count)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   typedef struct {
      logic        is_fault;
      int unsigned cyc;
      logic [19:0] vpn;
      logic [19:0] ppn;
      logic [3:0]  flags;
      logic        g;
      logic [7:0]  asid;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      int unsigned stall;
      int unsigned delay;
   } mem_t;

   exp_t sbq[$];
   mem_t memq[$];

   task automatic push_exp(input logic f, input int unsigned c, input logic [19:0] vpn,
                           input logic [19:0] ppn, input logic [3:0] fl, input logic g,
                           input logic [7:0] asid);
      exp_t e;
      e.is_fault = f; e.cyc = c; e.vpn = vpn; e.ppn = ppn;
      e.flags = fl; e.g = g; e.asid = asid;
      sbq.push_back(e);
   endtask

   task automatic push_mem(input logic [31:0] addr, input logic [31:0] data, input logic err,
                           input int unsigned stall, input int unsigned delay);
      mem_t m;
      m.addr = addr; m.data = data; m.err = err; m.stall = stall; m.delay = delay;
      memq.push_back(m);
   endtask

   // Memory model: all inputs change on the falling edge.
   mem_t        cur;
   logic        outst;
   int unsigned stall_cnt;
   int unsigned resp_timer;
   logic [31:0] hold_addr;

   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
      outst      = 1'b0;
      stall_cnt  = 0;
      resp_timer = 0;
      hold_addr  = '0;
      forever begin
         @(negedge clk);
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         mem_resp_err   = 1'b0;
         if (outst) begin
            if (resp_timer == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = cur.data;
               mem_resp_err   = cur.err;
               outst = 1'b0;
            end else begin
               resp_timer--;
            end
         end else if (mem_req_valid && rst_n) begin
            if (stall_cnt == 0) begin
               if (memq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_mem_req: addr 0x%0h with nothing expected", mem_req_addr);
               end else begin
                  cur = memq[0];
                  hold_addr = mem_req_addr;
                  chk("mem_req_addr", mem_req_addr, cur.addr);
               end
            end else begin
               chk("mem_req_addr_stable", mem_req_addr, hold_addr);
            end
            if (memq.size() != 0) begin
               if (stall_cnt < cur.stall) begin
                  stall_cnt++;
               end else begin
                  mem_req_ready = 1'b1;
                  stall_cnt  = 0;
                  outst      = 1'b1;
                  resp_timer = cur.delay;
                  void'(memq.pop_front());
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT pulses.
   exp_t mon_e;
   always @(negedge clk) begin
      if (rst_n && (refill_valid || fault_valid)) begin
         chk("pulse_exclusive", {31'b0, refill_valid & fault_valid}, 32'd0);
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse: refill=%0b fault=%0b with nothing expected (cycle %0d)",
                     refill_valid, fault_valid, cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk("pulse_is_fault", {31'b0, fault_valid}, {31'b0, mon_e.is_fault});
            chk("pulse_cycle", cyc, mon_e.cyc);
            if (mon_e.is_fault) begin
               chk("fault_vpn", {12'b0, fault_vpn}, {12'b0, mon_e.vpn});
            end else begin
               chk("refill_vpn",    {12'b0, refill_vpn},   {12'b0, mon_e.vpn});
               chk("refill_ppn",    {12'b0, refill_ppn},   {12'b0, mon_e.ppn});
               chk("refill_flags",  {28'b0, refill_flags}, {28'b0, mon_e.flags});
               chk("refill_global", {31'b0, refill_global},{31'b0, mon_e.g});
               chk("refill_asid",   {24'b0, refill_asid},  {24'b0, mon_e.asid});
            end
         end
      end
   end

   task automatic do_miss(input logic [19:0] vpn, input logic [7:0] asid,
                          input logic [19:0] root, output int unsigned acc);
      int unsigned n;
      miss_valid = 1'b1;
      miss_vpn   = vpn;
      miss_asid  = asid;
      root_ppn   = root;
      n = 0;
      while (!miss_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!miss_ready) begin
         total++; bad++;
         $display("FAIL miss_accept_timeout: miss_ready still 0 after %0d cycles", n);
      end
      acc = cyc;
      @(negedge clk);
      miss_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while ((busy || sbq.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy || sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, sbq.size());
      end
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int unsigned acc, acc2;

   initial begin
      rst_n = 1'b0; miss_valid = 1'b0; miss_vpn = '0; miss_asid = '0;
      root_ppn = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("reset_miss_ready", {31'b0, miss_ready}, 32'd1);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_walk_count", {16'b0, walk_count}, 32'd0);
      chk("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);

      // Two-level walk
      push_mem(32'h00080120, 32'h00024001, 1'b0, 0, 0);
      push_mem(32'h00090D14, 32'h2AF378C7, 1'b0, 0, 0);
      do_miss(20'h12345, 8'h07, 20'h00080, acc);
      push_exp(1'b0, acc + 5, 20'h12345, 20'hABCDE, 4'h3, 1'b0, 8'h07);
      wait_idle();
      chk("walk_count_two_level", {16'b0, walk_count}, 32'd1);

      // Superpage
      push_mem(32'h00080120, 32'h04B0004B, 1'b0, 0, 0);
      do_miss(20'h12345, 8'h11, 20'h00080, acc);
      push_exp(1'b0, acc + 3, 20'h12345, 20'h12F45, 4'h5, 1'b0, 8'h11);
      wait_idle();
      chk("walk_count_superpage", {16'b0, walk_count}, 32'd2);

      // Misaligned superpage
      push_mem(32'h00080120, 32'h04B0044B, 1'b0, 0, 0);
      do_miss(20'h12345, 8'h11, 20'h00080, acc);
      push_exp(1'b1, acc + 3, 20'h12345, 20'h0, 4'h0, 1'b0, 8'h0);
      wait_idle();
      chk("walk_count_misaligned", {16'b0, walk_count}, 32'd2);
      chk("refill_ppn_held", {12'b0, refill_ppn}, 32'h12F45);

      // Global inherited from the level-1 pointer
      push_mem(32'h00080004, 32'h00024021, 1'b0, 0, 0);
      push_mem(32'h00090004, 32'h2AF378C7, 1'b0, 0, 0);
      do_miss(20'h00401, 8'h22, 20'h00080, acc);
      push_exp(1'b0, acc + 5, 20'h00401, 20'hABCDE, 4'h3, 1'b1, 8'h22);
      wait_idle();
      chk("walk_count_global", {16'b0, walk_count}, 32'd3);

      // L0 PTE with V=0
      push_mem(32'h00080120, 32'h00024001, 1'b0, 0, 0);
      push_mem(32'h00090D14, 32'h2AF378C6, 1'b0, 0, 0);
      do_miss(20'h12345, 8'h03, 20'h00080, acc);
      push_exp(1'b1, acc + 5, 20'h12345, 20'h0, 4'h0, 1'b0, 8'h0);
      wait_idle();

      // W without R at L1
      push_mem(32'h00080120, 32'h00000005, 1'b0, 0, 0);
      do_miss(20'h12345, 8'h03, 20'h00080, acc);
      push_exp(1'b1, acc + 3, 20'h12345, 20'h0, 4'h0, 1'b0, 8'h0);
      wait_idle();

      // Bus error on an otherwise valid superpage PTE
      push_mem(32'h00080120, 32'h04B0004B, 1'b1, 0, 0);
      do_miss(20'h12345, 8'h03, 20'h00080, acc);
      push_exp(1'b1, acc + 3, 20'h12345, 20'h0, 4'h0, 1'b0, 8'h0);
      wait_idle();
      chk("walk_count_after_faults", {16'b0, walk_count}, 32'd3);

      // Backpressure on the L1 request plus a second miss held off
      push_mem(32'h00080120, 32'h00024001, 1'b0, 3, 0);
      push_mem(32'h00090D14, 32'h2AF378C7, 1'b0, 0, 0);
      push_mem(32'h00080120, 32'h04B0004B, 1'b0, 0, 0);
      do_miss(20'h12345, 8'h07, 20'h00080, acc);
      push_exp(1'b0, acc + 8, 20'h12345, 20'hABCDE, 4'h3, 1'b0, 8'h07);
      do_miss(20'h12345, 8'h09, 20'h00080, acc2);
      chk("second_miss_accept_cycle", acc2, acc + 9);
      push_exp(1'b0, acc2 + 3, 20'h12345, 20'h12F45, 4'h5, 1'b0, 8'h09);
      wait_idle();
      chk("walk_count_backpressure", {16'b0, walk_count}, 32'd5);

      // Flush in L0_WAIT with a 2-cycle response delay
      push_mem(32'h00080120, 32'h00024001, 1'b0, 0, 0);
      push_mem(32'h00090D14, 32'h2AF378C7, 1'b0, 0, 2);
      do_miss(20'h12345, 8'h07, 20'h00080, acc);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      chk("flush_ready_during_drain", {31'b0, miss_ready}, 32'd0);
      @(negedge clk);
      chk("flush_ready_after_resp", {31'b0, miss_ready}, 32'd1);
      chk("walk_count_flush", {16'b0, walk_count}, 32'd5);

      // Reset in L1_WAIT, stray response afterwards
      push_mem(32'h00080120, 32'h04B0004B, 1'b0, 0, 2);
      do_miss(20'h12345, 8'h07, 20'h00080, acc);
      @(negedge clk);
      chk("busy_before_reset", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_miss_ready", {31'b0, miss_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_walk_count", {16'b0, walk_count}, 32'd0);
      chk("rst_refill_ppn", {12'b0, refill_ppn}, 32'd0);
      chk("rst_refill_asid", {24'b0, refill_asid}, 32'd0);
      chk("rst_fault_vpn", {12'b0, fault_vpn}, 32'd0);
      chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_no_pulse_pending", {31'b0, refill_valid | fault_valid}, 32'd0);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      chk("mem_queue_drained", memq.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
